// File: rtl/lane_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_accumulator_pkg
// Brief    : Shared constants and FSM encodings for the lane accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package lane_accumulator_pkg;

    localparam int c_num_lanes = 4;
    localparam int c_lane_w    = 2;
    localparam int c_acc_width = 12;    // shared with the downstream scaler IN_WIDTH

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_accumulator_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Brief    : Unsigned saturating adder, narrow addend into a wide accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module sat_add
    import lane_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH  = c_acc_width,
    parameter int DATA_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0]  i_acc,
    input  logic [DATA_WIDTH-1:0] i_addend,
    output logic [ACC_WIDTH-1:0]  o_sum
);

    logic [ACC_WIDTH:0] w_wide;

    assign w_wide = {1'b0, i_acc} + (ACC_WIDTH + 1)'(i_addend);
    assign o_sum  = w_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_wide[ACC_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/lane_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : lane_accumulator
// Brief    : Windowed saturating per-lane sums handed to the vector scaler.
// Revision : 1.0 - initial release
// ============================================================================
module lane_accumulator
    import lane_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = c_acc_width,
    parameter int WINDOW_LEN = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            sample_valid,
    input  logic [c_lane_w-1:0]             sample_lane,
    input  logic [DATA_WIDTH-1:0]           sample_data,
    input  logic                            scale_done,
    output logic [c_num_lanes*ACC_WIDTH-1:0] V_out,
    output logic [ACC_WIDTH-1:0]            max_value,
    output logic                            start,
    output logic                            overrun
);

    localparam int                 c_cnt_w = clog2_min1(WINDOW_LEN);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WINDOW_LEN - 1);

    logic [ACC_WIDTH-1:0]             r_acc [c_num_lanes];
    logic [c_cnt_w-1:0]               r_count;
    logic [1:0]                       r_state;

    logic [ACC_WIDTH-1:0]             w_sum;
    logic                             w_close;
    logic [ACC_WIDTH-1:0]             w_snap [c_num_lanes];
    logic [c_num_lanes*ACC_WIDTH-1:0] w_snap_flat;
    logic [ACC_WIDTH-1:0]             w_max_01;
    logic [ACC_WIDTH-1:0]             w_max_23;
    logic [ACC_WIDTH-1:0]             w_snap_max;

    sat_add #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_add (
        .i_acc    (r_acc[sample_lane]),
        .i_addend (sample_data),
        .o_sum    (w_sum)
    );

    assign w_close = sample_valid && (r_count == c_last);

    // Snapshot includes the closing sample on its own lane.
    genvar gi;
    generate
        for (gi = 0; gi < c_num_lanes; gi++) begin : g_snap
            assign w_snap[gi] = (sample_lane == c_lane_w'(gi)) ? w_sum : r_acc[gi];
            assign w_snap_flat[gi*ACC_WIDTH +: ACC_WIDTH] = w_snap[gi];
        end
    endgenerate

    assign w_max_01   = (w_snap[0] > w_snap[1]) ? w_snap[0] : w_snap[1];
    assign w_max_23   = (w_snap[2] > w_snap[3]) ? w_snap[2] : w_snap[3];
    assign w_snap_max = (w_max_01 > w_max_23) ? w_max_01 : w_max_23;

    // Accumulators restart on every window close, independent of the output FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_num_lanes; i++) r_acc[i] <= '0;
            r_count <= '0;
        end else if (clear) begin
            for (int i = 0; i < c_num_lanes; i++) r_acc[i] <= '0;
            r_count <= '0;
        end else if (sample_valid) begin
            if (w_close) begin
                for (int i = 0; i < c_num_lanes; i++) r_acc[i] <= '0;
                r_count <= '0;
            end else begin
                r_acc[sample_lane] <= w_sum;
                r_count            <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            V_out     <= '0;
            max_value <= '0;
            start     <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            r_state <= c_st_idle;
            start   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    start <= 1'b0;
                    if (w_close) begin
                        V_out     <= w_snap_flat;
                        max_value <= w_snap_max;
                        start     <= 1'b1;
                        r_state   <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    start   <= 1'b0;
                    r_state <= c_st_wait;
                    if (w_close) overrun <= 1'b1;
                end
                c_st_wait: begin
                    start <= 1'b0;
                    if (scale_done && w_close) begin
                        V_out     <= w_snap_flat;
                        max_value <= w_snap_max;
                        start     <= 1'b1;
                        r_state   <= c_st_issue;
                    end else if (scale_done) begin
                        r_state <= c_st_idle;
                    end else if (w_close) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    start   <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_accumulator
// Brief    : Scoreboard bench for two lane_accumulator instances (windows 4, 20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_accumulator;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       sample_valid;
    logic [1:0] sample_lane;
    logic [7:0] sample_data;
    logic       scale_done;

    logic [47:0] v_a  [2];
    logic [11:0] mx_a [2];
    logic        st_a [2];
    logic        ov_a [2];

    int tests = 0;
    int fails = 0;

    lane_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(12), .WINDOW_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
        .sample_lane(sample_lane), .sample_data(sample_data), .scale_done(scale_done),
        .V_out(v_a[0]), .max_value(mx_a[0]), .start(st_a[0]), .overrun(ov_a[0])
    );

    lane_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(12), .WINDOW_LEN(20)) u_dut20 (
        .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
        .sample_lane(sample_lane), .sample_data(sample_data), .scale_done(scale_done),
        .V_out(v_a[1]), .max_value(mx_a[1]), .start(st_a[1]), .overrun(ov_a[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    // Reference model: window sums, a "scaler busy" flag and the accepted snapshot.
    int          win_len [2] = '{4, 20};
    int          sums    [2][4];
    int          cnt     [2];
    bit          busy    [2];
    bit          issued  [2];
    bit          e_start [2];
    bit          e_ovr   [2];
    logic [47:0] e_v     [2];
    logic [11:0] e_mx    [2];
    logic [59:0] q0 [$];
    logic [59:0] q1 [$];

    task automatic model_step(input int d);
        int          snap [4];
        bit          closed;
        bit          was_issued;
        bit          done_eff;
        int          s;
        int          m;
        logic [47:0] sv;
        was_issued = issued[d];
        issued[d]  = 0;
        e_start[d] = 0;
        closed     = 0;
        if (clear) begin
            for (int i = 0; i < 4; i++) sums[d][i] = 0;
            cnt[d]   = 0;
            e_ovr[d] = 0;
            busy[d]  = 0;
            return;
        end
        if (sample_valid) begin
            s = sums[d][sample_lane] + int'(sample_data);
            sums[d][sample_lane] = (s > 4095) ? 4095 : s;
            cnt[d]++;
            if (cnt[d] == win_len[d]) begin
                closed = 1;
                for (int i = 0; i < 4; i++) begin
                    snap[i]    = sums[d][i];
                    sums[d][i] = 0;
                end
                cnt[d] = 0;
            end
        end
        done_eff = scale_done && busy[d] && !was_issued;
        if (done_eff) busy[d] = 0;
        if (closed) begin
            if (!busy[d]) begin
                m = 0;
                for (int i = 0; i < 4; i++) begin
                    sv[i*12 +: 12] = 12'(snap[i]);
                    if (snap[i] > m) m = snap[i];
                end
                e_v[d]     = sv;
                e_mx[d]    = 12'(m);
                busy[d]    = 1;
                issued[d]  = 1;
                e_start[d] = 1;
                if (d == 0) q0.push_back({12'(m), sv});
                else        q1.push_back({12'(m), sv});
            end else begin
                e_ovr[d] = 1;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) sums[d][i] = 0;
                cnt[d] = 0; busy[d] = 0; issued[d] = 0;
                e_start[d] = 0; e_ovr[d] = 0; e_v[d] = '0; e_mx[d] = '0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // Monitor: per-cycle state checks plus scoreboard pop on every start pulse.
    always @(negedge clk) begin
        logic [59:0] ent;
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                chk("start", d, 64'(st_a[d]), 64'(e_start[d]));
                chk("overrun", d, 64'(ov_a[d]), 64'(e_ovr[d]));
                chk("v_hold", d, 64'(v_a[d]), 64'(e_v[d]));
                if (st_a[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("sb_unexpected_start", d, 64'd1, 64'd0);
                    end else begin
                        ent = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk("sb_v_out", d, 64'(v_a[d]), 64'(ent[47:0]));
                        chk("sb_max", d, 64'(mx_a[d]), 64'(ent[59:48]));
                    end
                end
            end
        end
    end

    task automatic step(input bit v, input int ln, input int dat, input bit dn, input bit clr);
        sample_valid = v;
        sample_lane  = 2'(ln);
        sample_data  = 8'(dat);
        scale_done   = dn;
        clear        = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_v_out", d, 64'(v_a[d]), 64'd0);
            chk("rst_max", d, 64'(mx_a[d]), 64'd0);
            chk("rst_start", d, 64'(st_a[d]), 64'd0);
            chk("rst_overrun", d, 64'(ov_a[d]), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; sample_valid = 1'b0;
        sample_lane = '0; sample_data = '0; scale_done = 1'b0;
        #12;
        chk_zero_outputs();
        @(posedge clk);
        #2 reset = 1'b0;
        idle(10);

        // Basic window with idle gaps
        for (int l = 0; l < 4; l++) begin
            step(1, l, 10 * (l + 1), 0, 0);
            if (l < 3) idle(2);
        end
        chk("basic_start", 0, 64'(st_a[0]), 64'd1);
        chk("basic_v", 0, 64'(v_a[0]), 64'h028_01E_014_00A);
        chk("basic_max", 0, 64'(mx_a[0]), 64'd40);
        idle(1);
        chk("basic_start_low", 0, 64'(st_a[0]), 64'd0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 3, 1, 0, 0);
        chk("fresh_window_v", 0, 64'(v_a[0]), 64'h004_000_000_000);
        idle(1);
        step(0, 0, 0, 1, 0);

        // Saturation on the 20-sample instance
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 2, 255, 0, 0);
        chk("sat_start", 1, 64'(st_a[1]), 64'd1);
        chk("sat_v", 1, 64'(v_a[1]), 64'h000_FFF_000_000);
        chk("sat_max", 1, 64'(mx_a[1]), 64'hFFF);
        idle(1);
        step(0, 0, 0, 1, 0);

        // Overrun: second window dropped, third accepted after done
        step(0, 0, 0, 0, 1);
        for (int l = 0; l < 4; l++) step(1, l, l + 1, 0, 0);
        for (int l = 0; l < 4; l++) step(1, l, 9, 0, 0);
        chk("ovr_flag", 0, 64'(ov_a[0]), 64'd1);
        chk("ovr_v_kept", 0, 64'(v_a[0]), 64'h004_003_002_001);
        chk("ovr_no_start", 0, 64'(st_a[0]), 64'd0);
        idle(1);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 7, 0, 0);
        chk("ovr_w3_start", 0, 64'(st_a[0]), 64'd1);
        chk("ovr_w3_v", 0, 64'(v_a[0]), 64'h000_000_000_01C);
        chk("ovr_sticky", 0, 64'(ov_a[0]), 64'd1);
        idle(1);
        step(0, 0, 0, 0, 1);
        chk("ovr_cleared", 0, 64'(ov_a[0]), 64'd0);

        // Window close coincident with scale_done in WAIT
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 0);
        step(1, 1, 2, 1, 0);
        chk("simul_start", 0, 64'(st_a[0]), 64'd1);
        chk("simul_v", 0, 64'(v_a[0]), 64'h000_000_008_000);
        chk("simul_overrun", 0, 64'(ov_a[0]), 64'd0);

        // clear mid-window discards partial sums and the clear-cycle sample
        step(0, 0, 0, 0, 1);
        step(1, 1, 100, 0, 0);
        step(1, 1, 100, 0, 0);
        step(1, 1, 100, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 5, 0, 0);
        chk("clear_start", 0, 64'(st_a[0]), 64'd1);
        chk("clear_v", 0, 64'(v_a[0]), 64'h000_000_014_000);
        chk("clear_max", 0, 64'(mx_a[0]), 64'd20);

        // Randomized traffic
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 149) == 0));
        end

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_zero_outputs();
        @(posedge clk);
        #2 reset = 1'b0;
        idle(10);

        chk("sb_drain", 0, 64'(q0.size()), 64'd0);
        chk("sb_drain", 1, 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
